// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the EX-stage branch redirect sequencer.
// State encoding and the architectural delay-slot fall-through offset.
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_DS  = 2'b01,
    REDIRECT = 2'b10
  } brc_state_e;

  localparam int DELAY_SLOT_OFFSET = 8;

endpackage

// File: rtl/branch_redirect_ctrl_counters.sv
// Resolved-branch and mispredict performance counters.
// Both wrap modulo 2^CNT_W; en drops all updates during an exception flush.
module branch_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc_branch,
  input  logic             inc_mispred,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (en) begin
      if (inc_branch)
        branch_cnt <= branch_cnt + 1'b1;
      if (inc_mispred)
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: schedules the fetch redirect after the
// delay slot, pulses BHT updates and counts branches/mispredicts.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branchE,
  input  logic             stallE,
  input  logic             actual_takeE,
  input  logic             pred_takeE,
  input  logic [PC_W-1:0]  pc_branchE,
  input  logic [PC_W-1:0]  targetE,
  input  logic             ds_validD,
  input  logic             flush_exceptionM,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_fetchF,
  output logic             stall_reqE,
  output logic             bht_upd_valid,
  output logic [PC_W-1:0]  bht_upd_pc,
  output logic             bht_upd_taken,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  brc_state_e      state;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fix_pc;
  logic            resolve;
  logic            mispred;
  logic            handshake;

  assign resolve   = branchE & ~stallE & ~flush_exceptionM
                   & (state == IDLE);
  assign mispred   = actual_takeE ^ pred_takeE;
  assign fix_pc    = actual_takeE ? targetE
                   : pc_branchE + PC_W'(DELAY_SLOT_OFFSET);

  assign redirect_valid = (state == REDIRECT);
  assign handshake      = redirect_valid & redirect_ready;
  assign flush_fetchF   = handshake;
  assign stall_reqE     = (state != IDLE);
  assign redirect_pc    = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc_q          <= '0;
      bht_upd_valid <= 1'b0;
      bht_upd_pc    <= '0;
      bht_upd_taken <= 1'b0;
    end else begin
      bht_upd_valid <= resolve;
      if (resolve) begin
        bht_upd_pc    <= pc_branchE;
        bht_upd_taken <= actual_takeE;
      end
      // The exception path owns fetch: drop any pending redirect.
      if (flush_exceptionM) begin
        state <= IDLE;
        pc_q  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (resolve && mispred) begin
              pc_q  <= fix_pc;
              state <= ds_validD ? REDIRECT : WAIT_DS;
            end
          end
          WAIT_DS: begin
            if (ds_validD)
              state <= REDIRECT;
          end
          REDIRECT: begin
            if (handshake)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  branch_perf_counters #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (~flush_exceptionM),
    .inc_branch (resolve),
    .inc_mispred(resolve & mispred),
    .branch_cnt (branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: vector table plus
// hand sequences for delay slot, backpressure, flush, reset and wrap.
module tb_branch_redirect_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             branchE, stallE, actual_takeE, pred_takeE;
  logic [PC_W-1:0]  pc_branchE, targetE;
  logic             ds_validD, flush_exceptionM, redirect_ready;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_fetchF, stall_reqE;
  logic             bht_upd_valid;
  logic [PC_W-1:0]  bht_upd_pc;
  logic             bht_upd_taken;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .PC_W (PC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .branchE         (branchE),
    .stallE          (stallE),
    .actual_takeE    (actual_takeE),
    .pred_takeE      (pred_takeE),
    .pc_branchE      (pc_branchE),
    .targetE         (targetE),
    .ds_validD       (ds_validD),
    .flush_exceptionM(flush_exceptionM),
    .redirect_ready  (redirect_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_fetchF    (flush_fetchF),
    .stall_reqE      (stall_reqE),
    .bht_upd_valid   (bht_upd_valid),
    .bht_upd_pc      (bht_upd_pc),
    .bht_upd_taken   (bht_upd_taken),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  typedef struct {
    logic        br, st, act, pred;
    logic [31:0] pc, tgt;
    logic        ds, fl, rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ff, sr, bv;
    logic [31:0] bpc;
    logic        bt;
    logic [3:0]  bc, mc;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, st, act, pred,
                       input logic [31:0] pc, tgt,
                       input logic ds, fl, rdy);
    branchE          = br;
    stallE           = st;
    actual_takeE     = act;
    pred_takeE       = pred;
    pc_branchE       = pc;
    targetE          = tgt;
    ds_validD        = ds;
    flush_exceptionM = fl;
    redirect_ready   = rdy;
  endtask

  task automatic idle(input logic ds, rdy);
    drive(0, 0, 0, 0, 32'h0, 32'h0, ds, 0, rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic rv,
                         input logic [31:0] rpc,
                         input logic ff, sr, bv,
                         input logic [31:0] bpc,
                         input logic bt,
                         input logic [3:0] bc, mc);
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
    chk({tag, ".redirect_pc"}, redirect_pc, rpc);
    chk({tag, ".flush_fetchF"}, 32'(flush_fetchF), 32'(ff));
    chk({tag, ".stall_reqE"}, 32'(stall_reqE), 32'(sr));
    chk({tag, ".bht_upd_valid"}, 32'(bht_upd_valid), 32'(bv));
    chk({tag, ".bht_upd_pc"}, bht_upd_pc, bpc);
    chk({tag, ".bht_upd_taken"}, 32'(bht_upd_taken), 32'(bt));
    chk({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(bc));
    chk({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(mc));
  endtask

  initial begin
    // inputs | rv rpc ff sr bv bpc bt bc mc (observed this cycle)
    tbl[0] = '{0,0,0,0,32'h0,32'h0,0,0,0,
               0,32'h0,0,0,0,32'h0,0,4'd0,4'd0};
    tbl[1] = '{1,0,1,1,32'h1000,32'h1800,1,0,0,
               0,32'h0,0,0,0,32'h0,0,4'd0,4'd0};
    tbl[2] = '{0,0,0,0,32'h0,32'h0,0,0,0,
               0,32'h0,0,0,1,32'h1000,1,4'd1,4'd0};
    tbl[3] = '{1,0,0,1,32'h2000,32'h2800,1,0,1,
               0,32'h0,0,0,0,32'h1000,1,4'd1,4'd0};
    tbl[4] = '{0,0,0,0,32'h0,32'h0,0,0,1,
               1,32'h2008,1,1,1,32'h2000,0,4'd2,4'd1};
    tbl[5] = '{0,0,0,0,32'h0,32'h0,0,0,1,
               0,32'h2008,0,0,0,32'h2000,0,4'd2,4'd1};
    tbl[6] = '{1,1,1,0,32'h3000,32'h3800,1,0,1,
               0,32'h2008,0,0,0,32'h2000,0,4'd2,4'd1};
    tbl[7] = '{0,0,0,0,32'h0,32'h0,0,0,1,
               0,32'h2008,0,0,0,32'h2000,0,4'd2,4'd1};

    rst = 1'b1;
    idle(0, 0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].br, tbl[i].st, tbl[i].act, tbl[i].pred,
            tbl[i].pc, tbl[i].tgt, tbl[i].ds, tbl[i].fl, tbl[i].rdy);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].rv, tbl[i].rpc,
              tbl[i].ff, tbl[i].sr, tbl[i].bv, tbl[i].bpc,
              tbl[i].bt, tbl[i].bc, tbl[i].mc);
      tick();
    end

    // Taken mispredict waiting for a late delay slot.
    drive(1, 0, 1, 0, 32'h3000, 32'h4000, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(i == 2, 1);
      #1;
      chk("wds.stall", 32'(stall_reqE), 32'd1);
      chk("wds.rv_low", 32'(redirect_valid), 32'd0);
      tick();
    end
    idle(0, 1);
    #1;
    chk("wds.rv", 32'(redirect_valid), 32'd1);
    chk("wds.rpc", redirect_pc, 32'h4000);
    chk("wds.ff", 32'(flush_fetchF), 32'd1);
    chk("wds.bc", 32'(branch_cnt), 32'd3);
    chk("wds.mc", 32'(mispred_cnt), 32'd2);
    tick();
    chk("wds.done_rv", 32'(redirect_valid), 32'd0);
    chk("wds.done_sr", 32'(stall_reqE), 32'd0);

    // Fetch backpressure holds the redirect stable.
    drive(1, 0, 0, 1, 32'h5000, 32'h5800, 1, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(0, 0);
      #1;
      chk("bp.rv", 32'(redirect_valid), 32'd1);
      chk("bp.rpc", redirect_pc, 32'h5008);
      chk("bp.ff_low", 32'(flush_fetchF), 32'd0);
      chk("bp.sr", 32'(stall_reqE), 32'd1);
      tick();
    end
    idle(0, 1);
    #1;
    chk("bp.ff", 32'(flush_fetchF), 32'd1);
    tick();
    chk("bp.done_rv", 32'(redirect_valid), 32'd0);
    chk("bp.bc", 32'(branch_cnt), 32'd4);
    chk("bp.mc", 32'(mispred_cnt), 32'd3);

    // Exception flush while waiting for the delay slot.
    drive(1, 0, 1, 0, 32'h6000, 32'h6000, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1);
    #1;
    chk("exc.sr_before", 32'(stall_reqE), 32'd1);
    tick();
    idle(1, 1);
    #1;
    chk("exc.sr", 32'(stall_reqE), 32'd0);
    chk("exc.rv", 32'(redirect_valid), 32'd0);
    tick();
    chk("exc.stay_rv", 32'(redirect_valid), 32'd0);
    drive(1, 0, 1, 0, 32'h6100, 32'h6200, 1, 1, 1);
    tick();
    idle(0, 1);
    #1;
    chk("exc.bv", 32'(bht_upd_valid), 32'd0);
    chk("exc.bc", 32'(branch_cnt), 32'd5);
    chk("exc.mc", 32'(mispred_cnt), 32'd4);
    chk("exc.sr2", 32'(stall_reqE), 32'd0);

    // Reset in the middle of a pending redirect.
    drive(1, 0, 0, 1, 32'h7000, 32'h7800, 1, 0, 0);
    tick();
    idle(0, 0);
    #1;
    chk("rst.pre_rv", 32'(redirect_valid), 32'd1);
    chk("rst.pre_bc", 32'(branch_cnt), 32'd6);
    rst = 1'b1;
    tick();
    chk_all("rst", 0, 32'h0, 0, 0, 0, 32'h0, 0, 4'd0, 4'd0);
    rst = 1'b0;

    // Sixteen correct resolves wrap the 4-bit branch counter.
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0, 32'(i * 4), 32'h0, 1, 0, 1);
      tick();
      chk($sformatf("wrap%0d", i), 32'(branch_cnt),
          32'((i + 1) % 16));
    end
    idle(0, 0);
    chk("wrap.mc", 32'(mispred_cnt), 32'd0);
    chk("wrap.sr", 32'(stall_reqE), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Execute-stage branch resolution sequencer for the 5-stage MIPS pipeline. It consumes the branch checker's actual-taken result and the fetch-time prediction for a resolving branch. It then schedules the fetch redirect, respecting the architectural delay slot, and emits BHT update pulses and performance counters. It sits between the EX branch checker and the fetch-PC mux / hazard unit.

Parameters:
PC_W, 32, program counter width
CNT_W, 32, width of branch and mispredict performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
branchE  in  1  valid branch/jump-conditional in EX this cycle
stallE  in  1  EX stage stalled; resolution not accepted while high
actual_takeE  in  1  branch outcome from branch checker
pred_takeE  in  1  prediction made at fetch for this branch
pc_branchE  in  PC_W  PC of resolving branch
targetE  in  PC_W  computed taken target
ds_validD  in  1  delay-slot instruction present in ID
flush_exceptionM  in  1  exception/eret flush from MEM, highest priority
redirect_ready  in  1  fetch unit accepts redirect this cycle
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  PC_W  corrected fetch PC
flush_fetchF  out  1  kill wrong-path instruction in IF
stall_reqE  out  1  hold EX and earlier while a redirect is pending
bht_upd_valid  out  1  one-cycle BHT update strobe
bht_upd_pc  out  PC_W  PC to update
bht_upd_taken  out  1  outcome to train
branch_cnt  out  CNT_W  resolved branches
mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE. All outputs 0, counters 0, redirect_pc 0.
- Resolve event R = branchE & ~stallE & ~flush_exceptionM & state==IDLE. branchE outside IDLE cannot occur because stall_reqE is high; it is ignored.
- On R (cycle t), registered to t+1:
  - bht_upd_valid=1, with bht_upd_pc=pc_branchE and bht_upd_taken=actual_takeE.
  - branch_cnt += 1.
  - If actual_takeE != pred_takeE: mispred_cnt += 1.
  - Counters wrap modulo 2^CNT_W.
- Mispredict on R:
  - Latch correct PC: actual_takeE ? targetE : pc_branchE + 8, truncated to PC_W.
  - Next state is REDIRECT if ds_validD=1 at t, otherwise WAIT_DS.
  - A correct prediction stays in IDLE.
- WAIT_DS: waits for the delay slot to reach ID. When ds_validD=1, move to REDIRECT next cycle. There is no timeout.
- REDIRECT:
  - redirect_valid=1 and redirect_pc holds stable.
  - When redirect_valid & redirect_ready, go to IDLE next cycle. flush_fetchF=1 in that same handshake cycle, combinational from the handshake.
- stall_reqE = (state != IDLE), combinational from state.
- redirect_valid is low in every state except REDIRECT.
- flush_exceptionM in any cycle:
  - Next state IDLE, and any latched redirect is dropped.
  - No R is taken that cycle: no BHT update, no counter change.
  - If it coincides with a redirect handshake, flush_fetchF still asserts, but the exception path owns fetch.
- rst mid-operation returns everything to reset values on the next edge.
- Latency: mispredict resolved at t with delay slot present gives the earliest redirect_valid at t+1.

Decomposition:
- Shared pipeline package holds:
  - state encoding typedef (IDLE=2'b00, WAIT_DS=2'b01, REDIRECT=2'b10);
  - DELAY_SLOT_OFFSET=8.
- One natural sub-module, branch_perf_counters, holding the branch/mispredict counters. Its inputs are the inc strobes and flush-qualified enables.
- The branch checker remains external, and its actual_takeE result is wired in.

Test Plan:
1. Correct prediction: branchE=1, pred=1, actual=1, pc=0x1000, ds_validD=1 -> t+1 bht_upd_valid=1, bht_upd_pc=0x1000, bht_upd_taken=1; branch_cnt=1, mispred_cnt=0; never redirect_valid; stall_reqE stays 0.
2. Not-taken mispredict: pred=1, actual=0, pc=0x2000, ds_validD=1, redirect_ready=1 -> t+1 redirect_valid=1, redirect_pc=0x2008, flush_fetchF=1, stall_reqE=1; t+2 IDLE; mispred_cnt=1.
3. Delay slot missing: pred=0, actual=1, target=0x4000, ds_validD=0 for 3 cycles then 1 -> stall_reqE=1 throughout, redirect_valid low until the cycle after ds_validD rises, redirect_pc=0x4000.
4. Backpressure: mispredict with redirect_ready=0 for 4 cycles -> redirect_valid and redirect_pc stable for 4 cycles, flush_fetchF only on the ready cycle.
5. Exception override: mispredict latched in WAIT_DS, then flush_exceptionM=1 -> next cycle IDLE, redirect_valid=0, stall_reqE=0. Coincident flush_exceptionM with branchE -> no bht_upd_valid, counters unchanged.
6. Reset mid-REDIRECT, and counter wrap with CNT_W=4 after 16 resolves -> all outputs 0 after reset; branch_cnt wraps 15->0.
